// File: rtl/lock_key_pkg.sv
// Shared constants, state encoding and parity helper for the c432 key loader.
// Build option: LOCK_KEY_PARITY_EN appends an even-parity bit to each load.
package lock_key_pkg;

    localparam int KEY_W = 11;
    localparam int P_W   = 4;
    localparam int X_W   = 7;

`ifdef LOCK_KEY_PARITY_EN
    localparam int LOAD_W = KEY_W + 1;
`else
    localparam int LOAD_W = KEY_W;
`endif

    localparam int CNT_W = $clog2(KEY_W + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_ARMED,
        ST_ERROR
    } lk_state_t;

    function automatic logic key_parity(input logic [KEY_W-1:0] k);
        return ^k;
    endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// Shadow shift register for the serial key: LSB-first capture, bit count, parity.
// Build option: LOCK_KEY_PARITY_EN enables the running parity accumulator.
module lock_key_shreg
    import lock_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             key_bit,
    output logic [KEY_W-1:0] shadow,
    output logic             par_ok,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Final bit is being accepted this cycle; the FSM leaves SHIFT on it.
    assign done = shift_en & (cnt == CNT_W'(LOAD_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (clr) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (shift_en) begin
            if (cnt < CNT_W'(KEY_W))
                shadow[cnt] <= key_bit;
            cnt <= cnt + 1'b1;
        end
    end

`ifdef LOCK_KEY_PARITY_EN
    logic par_run;

    // Accumulates key bits and the trailing parity bit; zero means even parity holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_run <= 1'b0;
        else if (clr)
            par_run <= 1'b0;
        else if (shift_en)
            par_run <= par_run ^ key_bit;
    end

    assign par_ok = ~par_run;
`else
    assign par_ok = 1'b1;
`endif

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c432 core; commits the 11-bit key atomically.
// Build option: LOCK_KEY_PARITY_EN adds a trailing even-parity check.
//
// state    | meaning
// ST_IDLE  | no key committed, waiting for load_start
// ST_SHIFT | accepting serial key bits (key_ready=1)
// ST_CHECK | one cycle: parity verdict, commit or zeroize
// ST_ARMED | committed key driven to the core
// ST_ERROR | last load failed parity, key outputs zero
module lock_key_loader
    import lock_key_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_start,
    input  logic           key_clear,
    input  logic           key_bit,
    input  logic           key_valid,
    output logic           key_ready,
    output logic [P_W-1:0] key_p,
    output logic [X_W-1:0] key_x,
    output logic           key_armed,
    output logic           key_err,
    output logic           busy
);

    lk_state_t        state_q, state_d;
    logic [KEY_W-1:0] shadow;
    logic             par_ok;
    logic             done;
    logic             clr;
    logic             accept;
    logic             commit;
    logic             fail;

    assign key_ready = (state_q == ST_SHIFT);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
    assign clr       = key_clear | load_start;
    assign accept    = key_ready & key_valid & ~clr;

    lock_key_shreg u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (accept),
        .key_bit  (key_bit),
        .shadow   (shadow),
        .par_ok   (par_ok),
        .done     (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        fail    = 1'b0;
        if (key_clear) begin
            state_d = ST_IDLE;
        end else if (load_start) begin
            state_d = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: if (done) state_d = ST_CHECK;
                ST_CHECK: begin
                    if (par_ok) begin
                        commit  = 1'b1;
                        state_d = ST_ARMED;
                    end else begin
                        fail    = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Key outputs move only on commit, fail, key_clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p     <= '0;
            key_x     <= '0;
            key_armed <= 1'b0;
            key_err   <= 1'b0;
        end else if (key_clear) begin
            key_p     <= '0;
            key_x     <= '0;
            key_armed <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            if (load_start)
                key_err <= 1'b0;
            if (commit) begin
                key_p     <= shadow[P_W-1:0];
                key_x     <= shadow[KEY_W-1:P_W];
                key_armed <= 1'b1;
                key_err   <= 1'b0;
            end
            if (fail) begin
                key_p     <= '0;
                key_x     <= '0;
                key_armed <= 1'b0;
                key_err   <= 1'b1;
            end
        end
    end

endmodule
